// File: rtl/ai_paddle_ctrl.sv
// Computer-player paddle controller: tracks a reaction-delayed ball Y with per-difficulty
// speed and a hysteresis deadband; difficulty 0 mirrors the human up/down buttons.
module ai_paddle_ctrl #(
  parameter int Y_W       = 10,
  parameter int SCREEN_H  = 480,
  parameter int PADDLE_H  = 64,
  parameter int DEADBAND  = 8,
  parameter int DLY_DEPTH = 16,
  parameter int DLY_L1    = 12,
  parameter int DLY_L2    = 6,
  parameter int DLY_L3    = 2,
  parameter int TICKS_M   = 50000,
  parameter int TICKS_L1  = 400000,
  parameter int TICKS_L2  = 200000,
  parameter int TICKS_L3  = 100000,
  parameter int TICK_W    = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           game_on,
  input  logic           wrap_mode,
  input  logic [1:0]     diff,
  input  logic           human_up,
  input  logic           human_down,
  input  logic           ball_valid,
  input  logic [Y_W-1:0] ball_y,
  output logic [Y_W-1:0] position,
  output logic           moving_up,
  output logic           moving_down
);

  localparam int SEL_W = (DLY_DEPTH > 1) ? $clog2(DLY_DEPTH) : 1;

  localparam logic [Y_W-1:0] MID_Y = Y_W'(SCREEN_H / 2);
  localparam logic [Y_W-1:0] LO_Y  = Y_W'(PADDLE_H / 2);
  localparam logic [Y_W-1:0] HI_Y  = Y_W'(SCREEN_H - 1 - PADDLE_H / 2);
  localparam logic [Y_W-1:0] TOP_Y = Y_W'(SCREEN_H - 1);

  localparam logic signed [Y_W:0]   DB_E  = (Y_W + 1)'(DEADBAND);
  localparam logic signed [Y_W+1:0] ONE_E = (Y_W + 2)'(1);
  localparam logic signed [Y_W+1:0] LO_E  = (Y_W + 2)'(PADDLE_H / 2);
  localparam logic signed [Y_W+1:0] HI_E  = (Y_W + 2)'(SCREEN_H - 1 - PADDLE_H / 2);
  localparam logic signed [Y_W+1:0] TOP_E = (Y_W + 2)'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    MIRROR,
    TRACK,
    HOLD
  } state_t;

  state_t state, state_next;

  logic [Y_W-1:0]    taps [DLY_DEPTH];
  logic [Y_W-1:0]    target;
  logic [SEL_W-1:0]  tap_sel;
  logic [TICK_W-1:0] tick, tick_max;
  logic [1:0]        diff_q;

  logic signed [Y_W:0]   err, abs_err;
  logic signed [Y_W+1:0] cand;
  logic [Y_W-1:0]        pos_next;
  logic cmd_up, cmd_down, tick_clear, do_step;

  // Ball history: tap 0 holds the newest sample, tap k the sample k strobes old.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the delay line is reset element by element so the paddle stays centred
      // until real ball samples have propagated down to the selected tap.
      for (int k = 0; k < DLY_DEPTH; k++) taps[k] <= MID_Y;
    end else if (ball_valid) begin
      taps[0] <= ball_y;
      for (int k = 1; k < DLY_DEPTH; k++) taps[k] <= taps[k-1];
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    tap_sel  = '0;
    tick_max = TICK_W'(TICKS_M - 1);
    case (diff)
      2'd1: begin tap_sel = SEL_W'(DLY_L1); tick_max = TICK_W'(TICKS_L1 - 1); end
      2'd2: begin tap_sel = SEL_W'(DLY_L2); tick_max = TICK_W'(TICKS_L2 - 1); end
      2'd3: begin tap_sel = SEL_W'(DLY_L3); tick_max = TICK_W'(TICKS_L3 - 1); end
      default: ;
    endcase
  end

  assign err     = $signed({1'b0, target}) - $signed({1'b0, position});
  assign abs_err = err[Y_W] ? -err : err;

  always_comb begin
    state_next = state;
    cmd_up     = 1'b0;
    cmd_down   = 1'b0;
    case (state)
      IDLE: begin
        if (game_on) state_next = (diff == 2'd0) ? MIRROR : TRACK;
      end
      MIRROR: begin
        if (diff != 2'd0) begin
          state_next = TRACK;
        end else begin
          cmd_up   = human_up & ~human_down;
          cmd_down = human_down & ~human_up;
        end
      end
      TRACK: begin
        if (diff == 2'd0) begin
          state_next = MIRROR;
        end else if (err == '0) begin
          state_next = HOLD;
        end else begin
          cmd_up   = err[Y_W];
          cmd_down = ~err[Y_W];
        end
      end
      HOLD: begin
        if (diff == 2'd0)        state_next = MIRROR;
        else if (abs_err > DB_E) state_next = TRACK;
      end
      default: state_next = IDLE;
    endcase
    if (!game_on) begin
      state_next = IDLE;
      cmd_up     = 1'b0;
      cmd_down   = 1'b0;
    end
  end

  // The speed divider restarts whenever the motion request changes in any way.
  assign tick_clear = ~(cmd_up | cmd_down)
                    | (cmd_up & moving_down) | (cmd_down & moving_up)
                    | (diff != diff_q) | ~game_on;
  assign do_step    = ~tick_clear & (tick == tick_max);

  always_comb begin
    cand     = cmd_up ? $signed({2'b00, position}) - ONE_E
                      : $signed({2'b00, position}) + ONE_E;
    pos_next = position;
    if (do_step) begin
      if (wrap_mode) begin
        if (cand < 0)          pos_next = TOP_Y;
        else if (cand > TOP_E) pos_next = '0;
        else                   pos_next = cand[Y_W-1:0];
      end else begin
        if (cand < LO_E)       pos_next = LO_Y;
        else if (cand > HI_E)  pos_next = HI_Y;
        else                   pos_next = cand[Y_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      target      <= MID_Y;
      position    <= MID_Y;
      tick        <= '0;
      diff_q      <= 2'd0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
    end else begin
      state       <= state_next;
      target      <= taps[tap_sel];
      position    <= pos_next;
      diff_q      <= diff;
      moving_up   <= cmd_up;
      moving_down <= cmd_down;
      if (tick_clear || tick == tick_max) tick <= '0;
      else                                tick <= tick + 1'b1;
    end
  end

endmodule
